sram_arbiter: RTL and testbench

Sequences the single shared base SRAM between instruction fetch (IF) and the MEM-stage data access that follows EX. It serialises requests, runs fixed-length SRAM read/write cycles, and performs LB/SB byte-lane handling. It produces per-requester acks and stall signals, which the pipeline uses in place of fixed bubble counts around LW/LB/SW/SB.

---
 rtl/sram_arbiter_pkg.sv | 19 +
 rtl/sram_arbiter_lane_align.sv | 44 ++++
 rtl/sram_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_sram_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the SRAM arbiter: access FSM states, default
// geometry/timing parameters and requester identifiers.
package sram_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        ACK   = 2'd3
    } arb_state_t;

    localparam int SRAM_ADDR_W         = 20;
    localparam int DEFAULT_WAIT_CYCLES = 1;

    // Requester identifiers stored in the grant register.
    localparam logic REQ_IF  = 1'b0;
    localparam logic REQ_MEM = 1'b1;

endpackage

// File: rtl/sram_arbiter_lane_align.sv
// sram_lane_align: combinational byte-lane handling for the SRAM arbiter.
//   Store side: i_st_lane/i_st_byte/i_st_wdata -> o_st_be_n (active-low
//               byte enables) and o_st_data (byte replicated on all lanes
//               for byte stores, unchanged for word stores).
//   Load side:  i_ld_lane/i_ld_byte/i_ld_word -> o_ld_data (selected byte
//               sign-extended for byte loads, raw word otherwise).
module sram_lane_align (
    input  logic [1:0]  i_st_lane,
    input  logic        i_st_byte,
    input  logic [31:0] i_st_wdata,
    output logic [3:0]  o_st_be_n,
    output logic [31:0] o_st_data,
    input  logic [1:0]  i_ld_lane,
    input  logic        i_ld_byte,
    input  logic [31:0] i_ld_word,
    output logic [31:0] o_ld_data
);

    logic [7:0] w_lanes [4];
    logic [7:0] w_ld_byte;

    // Lane 0 is bits [7:0].
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_lanes[gi] = i_ld_word[8*gi +: 8];
        end
    endgenerate

    assign w_ld_byte = w_lanes[i_ld_lane];
    assign o_ld_data = i_ld_byte ? {{24{w_ld_byte[7]}}, w_ld_byte} : i_ld_word;

    always_comb begin
        o_st_be_n = 4'b0000;
        o_st_data = i_st_wdata;
        if (i_st_byte) begin
            // Only the addressed lane is enabled; replicating the byte means
            // the data lane does not have to follow the address.
            o_st_be_n = ~(4'b0001 << i_st_lane);
            o_st_data = {4{i_st_wdata[7:0]}};
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: serialises instruction fetch (IF) and MEM-stage data
// accesses onto one asynchronous SRAM with fixed-length strobe cycles.
//   IF port : if_req/if_addr in, if_ack/if_rdata/if_stall out (read only).
//   MEM port: mem_req/mem_we/mem_byte/mem_addr/mem_wdata in,
//             mem_ack/mem_rdata/mem_stall out (LW/LB/SW/SB).
//   SRAM    : sram_addr, sram_data_o, sram_data_oe, sram_ce_n, sram_oe_n,
//             sram_we_n, sram_be_n out (all registered), sram_data_i in.
// Each access takes IDLE (grant) + WAIT_CYCLES+1 strobe cycles + ACK.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
    parameter int ADDR_W      = SRAM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_ack,
    output logic [31:0]       if_rdata,
    output logic              if_stall,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic              mem_byte,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_ack,
    output logic [31:0]       mem_rdata,
    output logic              mem_stall,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_data_o,
    output logic              sram_data_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [3:0]        sram_be_n,
    input  logic [31:0]       sram_data_i
);

    arb_state_t        r_state;
    logic              r_id;
    logic              r_byte;
    logic [1:0]        r_lane;
    logic [2:0]        r_wait;
    logic              r_last_mem;
    logic              r_if_ack;
    logic              r_mem_ack;
    logic [31:0]       r_if_rdata;
    logic [31:0]       r_mem_rdata;
    logic [ADDR_W-1:0] r_sram_addr;
    logic [31:0]       r_data_o;
    logic              r_data_oe;
    logic              r_ce_n;
    logic              r_oe_n;
    logic              r_we_n;
    logic [3:0]        r_be_n;

    logic              w_grant_mem;
    logic              w_grant_if;
    logic [3:0]        w_st_be_n;
    logic [31:0]       w_st_data;
    logic [31:0]       w_ld_data;
    logic              w_unused_addr_bits;

    // MEM has priority unless it was served last and IF is waiting.
    assign w_grant_mem = mem_req && !(r_last_mem && if_req);
    assign w_grant_if  = if_req && !w_grant_mem;

    // Address bits outside the SRAM word range carry no meaning here.
    assign w_unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                                  mem_addr[31:ADDR_W+2]};

    sram_lane_align u_lane_align (
        .i_st_lane  (mem_addr[1:0]),
        .i_st_byte  (mem_byte),
        .i_st_wdata (mem_wdata),
        .o_st_be_n  (w_st_be_n),
        .o_st_data  (w_st_data),
        .i_ld_lane  (r_lane),
        .i_ld_byte  (r_byte),
        .i_ld_word  (sram_data_i),
        .o_ld_data  (w_ld_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_id        <= REQ_IF;
            r_byte      <= 1'b0;
            r_lane      <= 2'b00;
            r_wait      <= 3'd0;
            r_last_mem  <= 1'b0;
            r_if_ack    <= 1'b0;
            r_mem_ack   <= 1'b0;
            r_if_rdata  <= 32'd0;
            r_mem_rdata <= 32'd0;
            r_sram_addr <= '0;
            r_data_o    <= 32'd0;
            r_data_oe   <= 1'b0;
            r_ce_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_be_n      <= 4'b1111;
        end else begin
            r_if_ack  <= 1'b0;
            r_mem_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_mem) begin
                        r_id        <= REQ_MEM;
                        r_last_mem  <= 1'b1;
                        r_byte      <= mem_byte;
                        r_lane      <= mem_addr[1:0];
                        r_sram_addr <= mem_addr[ADDR_W+1:2];
                        r_wait      <= 3'(WAIT_CYCLES);
                        r_ce_n      <= 1'b0;
                        if (mem_we) begin
                            r_state   <= WRITE;
                            r_we_n    <= 1'b0;
                            r_data_oe <= 1'b1;
                            r_be_n    <= w_st_be_n;
                            r_data_o  <= w_st_data;
                        end else begin
                            r_state <= READ;
                            r_oe_n  <= 1'b0;
                            r_be_n  <= 4'b0000;
                        end
                    end else if (w_grant_if) begin
                        r_id        <= REQ_IF;
                        r_last_mem  <= 1'b0;
                        r_byte      <= 1'b0;
                        r_lane      <= 2'b00;
                        r_sram_addr <= if_addr[ADDR_W+1:2];
                        r_wait      <= 3'(WAIT_CYCLES);
                        r_ce_n      <= 1'b0;
                        r_oe_n      <= 1'b0;
                        r_be_n      <= 4'b0000;
                        r_state     <= READ;
                    end
                end
                READ: begin
                    if (r_wait == 3'd0) begin
                        // Capture on the last strobe edge; the formatted word
                        // becomes visible together with the ack.
                        r_state <= ACK;
                        r_oe_n  <= 1'b1;
                        if (r_id == REQ_MEM) begin
                            r_mem_ack   <= 1'b1;
                            r_mem_rdata <= w_ld_data;
                        end else begin
                            r_if_ack   <= 1'b1;
                            r_if_rdata <= w_ld_data;
                        end
                    end else begin
                        r_wait <= r_wait - 3'd1;
                    end
                end
                WRITE: begin
                    if (r_wait == 3'd0) begin
                        r_state <= ACK;
                        r_we_n  <= 1'b1;
                        if (r_id == REQ_MEM) begin
                            r_mem_ack <= 1'b1;
                        end else begin
                            r_if_ack <= 1'b1;
                        end
                    end else begin
                        r_wait <= r_wait - 3'd1;
                    end
                end
                ACK: begin
                    // ce_n, address and data were held through this cycle
                    // for write hold time; release the bus now.
                    r_state   <= IDLE;
                    r_ce_n    <= 1'b1;
                    r_be_n    <= 4'b1111;
                    r_data_oe <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign if_ack       = r_if_ack;
    assign mem_ack      = r_mem_ack;
    assign if_rdata     = r_if_rdata;
    assign mem_rdata    = r_mem_rdata;
    assign if_stall     = if_req & ~r_if_ack;
    assign mem_stall    = mem_req & ~r_mem_ack;
    assign sram_addr    = r_sram_addr;
    assign sram_data_o  = r_data_o;
    assign sram_data_oe = r_data_oe;
    assign sram_ce_n    = r_ce_n;
    assign sram_oe_n    = r_oe_n;
    assign sram_we_n    = r_we_n;
    assign sram_be_n    = r_be_n;

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

    localparam int WAIT_CYCLES = 1;
    localparam int ADDR_W      = 20;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_ack;
    logic [31:0]       if_rdata;
    logic              if_stall;
    logic              mem_req;
    logic              mem_we;
    logic              mem_byte;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;
    logic              mem_stall;
    logic [ADDR_W-1:0] sram_addr;
    logic [31:0]       sram_data_o;
    logic              sram_data_oe;
    logic              sram_ce_n;
    logic              sram_oe_n;
    logic              sram_we_n;
    logic [3:0]        sram_be_n;
    logic [31:0]       sram_data_i;

    int checks   = 0;
    int failures = 0;

    // Expected held read data of each requester (changes only on its reads).
    logic [31:0] exp_if_hold;
    logic [31:0] exp_mem_hold;

    always #5 clk = ~clk;

    sram_arbiter #(
        .WAIT_CYCLES (WAIT_CYCLES),
        .ADDR_W      (ADDR_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_ack       (if_ack),
        .if_rdata     (if_rdata),
        .if_stall     (if_stall),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_byte     (mem_byte),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .mem_stall    (mem_stall),
        .sram_addr    (sram_addr),
        .sram_data_o  (sram_data_o),
        .sram_data_oe (sram_data_oe),
        .sram_ce_n    (sram_ce_n),
        .sram_oe_n    (sram_oe_n),
        .sram_we_n    (sram_we_n),
        .sram_be_n    (sram_be_n),
        .sram_data_i  (sram_data_i)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        is_if;
        logic        we;
        logic        byte_acc;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd_word;
        logic [19:0] exp_addr;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_be_n;
        logic [31:0] exp_data_o;
    } vec_t;

    vec_t vecs [10];

    // One complete access on the chosen port; inputs change on negedges.
    task automatic run_access(input vec_t v, input int idx);
        int          cyc;
        int          we_low;
        int          oe_low;
        logic        got_ack;
        logic        stall_wait;
        logic [19:0] seen_addr;
        logic [3:0]  seen_be;
        logic [31:0] seen_do;
        string       tag;
        tag        = $sformatf("v%0d", idx);
        cyc        = 0;
        we_low     = 0;
        oe_low     = 0;
        got_ack    = 1'b0;
        stall_wait = 1'b0;
        seen_addr  = '0;
        seen_be    = 4'hF;
        seen_do    = '0;
        sram_data_i = v.rd_word;
        if (v.is_if) begin
            if_req  = 1'b1;
            if_addr = v.addr;
        end else begin
            mem_req   = 1'b1;
            mem_we    = v.we;
            mem_byte  = v.byte_acc;
            mem_addr  = v.addr;
            mem_wdata = v.wdata;
        end
        while (!got_ack && cyc < 20) begin
            @(negedge clk);
            cyc++;
            got_ack = v.is_if ? if_ack : mem_ack;
            if (!got_ack) begin
                stall_wait = v.is_if ? if_stall : mem_stall;
                if (!sram_ce_n) seen_addr = sram_addr;
            end
            if (!sram_we_n) begin
                we_low++;
                seen_be = sram_be_n;
                seen_do = sram_data_o;
            end
            if (!sram_oe_n) begin
                oe_low++;
                seen_be = sram_be_n;
            end
        end
        check({tag, "_ack_seen"}, 32'(got_ack), 32'd1);
        check({tag, "_latency"}, 32'(cyc), 32'(WAIT_CYCLES + 2));
        check({tag, "_sram_addr"}, 32'(seen_addr), 32'(v.exp_addr));
        check({tag, "_stall_wait"}, 32'(stall_wait), 32'd1);
        check({tag, "_stall_at_ack"}, 32'(v.is_if ? if_stall : mem_stall), 32'd0);
        check({tag, "_other_ack"}, 32'(v.is_if ? mem_ack : if_ack), 32'd0);
        check({tag, "_be_n"}, 32'(seen_be), 32'(v.exp_be_n));
        if (v.we) begin
            check({tag, "_we_cycles"}, 32'(we_low), 32'(WAIT_CYCLES + 1));
            check({tag, "_oe_cycles"}, 32'(oe_low), 32'd0);
            check({tag, "_data_o"}, seen_do, v.exp_data_o);
            check({tag, "_oe_hold"}, 32'(sram_data_oe), 32'd1);
        end else begin
            check({tag, "_oe_cycles"}, 32'(oe_low), 32'(WAIT_CYCLES + 1));
            check({tag, "_we_cycles"}, 32'(we_low), 32'd0);
            if (v.is_if) exp_if_hold = v.exp_rdata;
            else         exp_mem_hold = v.exp_rdata;
        end
        check({tag, "_if_rdata"}, if_rdata, exp_if_hold);
        check({tag, "_mem_rdata"}, mem_rdata, exp_mem_hold);
        if_req  = 1'b0;
        mem_req = 1'b0;
        @(negedge clk);
        check({tag, "_ack_pulse"}, 32'({if_ack, mem_ack}), 32'd0);
        check({tag, "_ce_release"}, 32'({sram_ce_n, sram_data_oe}), 32'b10);
        $display("access %0d: if=%0b we=%0b byte=%0b addr=0x%08h latency=%0d if_rdata=0x%08h mem_rdata=0x%08h",
                 idx, v.is_if, v.we, v.byte_acc, v.addr, cyc, if_rdata, mem_rdata);
    endtask

    initial begin
        int   cyc;
        int   n_acks;
        int   last_cyc;
        logic any_ack;
        logic [1:0] exp_order [4];

        //            is_if we  byte addr           wdata          rd_word        exp_addr   exp_rdata      be_n     data_o
        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0,        32'hDEAD_BEEF, 20'h00004, 32'hDEAD_BEEF, 4'b0000, 32'h0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 32'h0000_0200, 32'h0,        32'h1234_5678, 20'h00080, 32'h1234_5678, 4'b0000, 32'h0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h0000_0103, 32'h0,        32'h80AA_BBCC, 20'h00040, 32'hFFFF_FF80, 4'b0000, 32'h0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 32'h0000_0100, 32'h0,        32'h80AA_BB7C, 20'h00040, 32'h0000_007C, 4'b0000, 32'h0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 32'h0000_0102, 32'h0,        32'h12A4_F055, 20'h00040, 32'hFFFF_FFA4, 4'b0000, 32'h0};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 32'h0000_0101, 32'h0000_005A, 32'h0,        20'h00040, 32'h0,         4'b1101, 32'h5A5A_5A5A};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 32'h0000_03FC, 32'hCAFE_F00D, 32'h0,        20'h000FF, 32'h0,         4'b0000, 32'hCAFE_F00D};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 32'h0000_0003, 32'h1234_56F1, 32'h0,        20'h00000, 32'h0,         4'b0111, 32'hF1F1_F1F1};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 32'h0000_0013, 32'h0,        32'h0BAD_F00D, 20'h00004, 32'h0BAD_F00D, 4'b0000, 32'h0};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 32'h0040_0010, 32'h0,        32'h7654_3210, 20'h00004, 32'h7654_3210, 4'b0000, 32'h0};

        exp_order[0] = 2'b10;  // {mem_ack, if_ack}
        exp_order[1] = 2'b01;
        exp_order[2] = 2'b10;
        exp_order[3] = 2'b01;

        rst_n       = 1'b0;
        if_req      = 1'b0;
        if_addr     = 32'h0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_byte    = 1'b0;
        mem_addr    = 32'h0;
        mem_wdata   = 32'h0;
        sram_data_i = 32'h0;
        exp_if_hold  = 32'h0;
        exp_mem_hold = 32'h0;

        // Reset values after the first edge with rst_n low.
        @(negedge clk);
        check("rst_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n}), 32'b111);
        check("rst_be_n", 32'(sram_be_n), 32'hF);
        check("rst_acks", 32'({if_ack, mem_ack}), 32'd0);
        check("rst_rdata", if_rdata | mem_rdata, 32'd0);
        check("rst_bus", 32'(sram_addr) | sram_data_o | 32'(sram_data_oe), 32'd0);
        $display("reset: ce_n=%0b oe_n=%0b we_n=%0b be_n=%b", sram_ce_n, sram_oe_n, sram_we_n, sram_be_n);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Both requesters held from reset: MEM, IF, MEM, IF, one access
        // every WAIT_CYCLES+3 cycles.
        if_addr     = 32'h0000_0040;
        mem_we      = 1'b0;
        mem_byte    = 1'b0;
        mem_addr    = 32'h0000_0080;
        sram_data_i = 32'h5555_AAAA;
        if_req      = 1'b1;
        mem_req     = 1'b1;
        n_acks      = 0;
        cyc         = 0;
        last_cyc    = 0;
        while (n_acks < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (mem_ack || if_ack) begin
                check($sformatf("arb_order%0d", n_acks), 32'({mem_ack, if_ack}), 32'(exp_order[n_acks]));
                check($sformatf("arb_spacing%0d", n_acks), 32'(cyc - last_cyc),
                      (n_acks == 0) ? 32'(WAIT_CYCLES + 2) : 32'(WAIT_CYCLES + 3));
                check($sformatf("arb_rdata%0d", n_acks), mem_ack ? mem_rdata : if_rdata, 32'h5555_AAAA);
                $display("arb grant %0d: mem_ack=%0b if_ack=%0b cycle=%0d", n_acks, mem_ack, if_ack, cyc);
                last_cyc = cyc;
                n_acks++;
            end
        end
        check("arb_ack_count", 32'(n_acks), 32'd4);
        if_req  = 1'b0;
        mem_req = 1'b0;
        exp_if_hold  = 32'h5555_AAAA;
        exp_mem_hold = 32'h5555_AAAA;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_access(vecs[i], i);
        end

        // Reset in the second WRITE cycle aborts the store.
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_byte  = 1'b1;
        mem_addr  = 32'h0000_0101;
        mem_wdata = 32'h0000_005A;
        cyc = 0;
        while (sram_we_n && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_write_started", 32'(sram_we_n), 32'd0);
        @(negedge clk);
        check("abort_second_cycle", 32'({sram_we_n, mem_ack}), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_strobes", 32'({sram_ce_n, sram_we_n, sram_data_oe}), 32'b110);
        check("abort_no_ack", 32'({mem_ack, if_ack}), 32'd0);
        check("abort_be_n", 32'(sram_be_n), 32'hF);
        check("abort_rdata", if_rdata | mem_rdata, 32'd0);
        $display("abort: we_n=%0b ce_n=%0b mem_ack=%0b", sram_we_n, sram_ce_n, mem_ack);
        mem_req = 1'b0;
        rst_n   = 1'b1;
        any_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            any_ack = any_ack | mem_ack | if_ack | ~sram_ce_n;
        end
        check("abort_idle", 32'(any_ack), 32'd0);
        exp_if_hold  = 32'h0;
        exp_mem_hold = 32'h0;
        run_access(vecs[2], 10);
        run_access(vecs[5], 11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
